// File: rtl/chip8_audio_pkg.sv
// Shared audio definitions for the CHIP-8 audio path (config_state and tone_gen).
package chip8_audio_pkg;

  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned VOL_W    = 3;
  localparam int unsigned TIMBRE_W = 2;
  localparam int unsigned PROD_W   = PWM_BITS + VOL_W;

  localparam logic [31:0] PHASE_INC_LO_DEF = 32'd4837980;
  localparam logic [31:0] PHASE_INC_HI_DEF = 32'd9675959;

  typedef enum logic [TIMBRE_W-1:0] {
    TIMBRE_SQUARE  = 2'd0,
    TIMBRE_PULSE25 = 2'd1,
    TIMBRE_SAW     = 2'd2,
    TIMBRE_TRI     = 2'd3
  } timbre_e;

endpackage

// File: rtl/tone_wave_shape.sv
// Combinational waveform lookup from the phase top byte, followed by the volume scaler.
module tone_wave_shape
  import chip8_audio_pkg::*;
(
  input  logic [TIMBRE_W-1:0] timbre,
  input  logic [PWM_BITS-1:0] p,
  input  logic [VOL_W-1:0]    vol,
  output logic [PWM_BITS-1:0] level_c
);

  logic [PWM_BITS-1:0] wave;
  logic [PROD_W-1:0]   product;

  always_comb begin
    wave = '0;
    case (timbre_e'(timbre))
      TIMBRE_SQUARE:  wave = p[PWM_BITS-1] ? '0 : '1;
      TIMBRE_PULSE25: wave = (p[PWM_BITS-1 -: 2] == 2'b00) ? '1 : '0;
      TIMBRE_SAW:     wave = p;
      TIMBRE_TRI:     wave = p[PWM_BITS-1] ? ~{p[PWM_BITS-2:0], 1'b0}
                                           :  {p[PWM_BITS-2:0], 1'b0};
      default:        wave = '0;
    endcase
  end

  // Keep the top byte of the 11-bit product: wave * vol / 8.
  always_comb begin
    product = PROD_W'(wave) * PROD_W'(vol);
    level_c = product[PROD_W-1 -: PWM_BITS];
  end

endmodule

// File: rtl/tone_gen.sv
// Phase-accumulator tone generator driving an 8-bit PWM audio output.
module tone_gen
  import chip8_audio_pkg::*;
#(
  parameter int unsigned          PHASE_W      = 32,
  parameter logic [PHASE_W-1:0]   PHASE_INC_LO = PHASE_W'(PHASE_INC_LO_DEF),
  parameter logic [PHASE_W-1:0]   PHASE_INC_HI = PHASE_W'(PHASE_INC_HI_DEF)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sound_on_in,
  input  logic [1:0]          timbre_in,
  input  logic                pitch_in,
  input  logic [2:0]          vol_in,
  output logic                pwm_out,
  output logic                audio_en_out,
  output logic [7:0]          level_out,
  output logic                sample_tick_out
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PHASE_W-1:0]  phase_q;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] scaled_c;
  logic [PHASE_W-1:0]  phase_inc_c;
  logic                wrap_c;

  assign wrap_c      = (pwm_cnt == '1);
  assign phase_inc_c = pitch_in ? PHASE_INC_HI : PHASE_INC_LO;

  tone_wave_shape u_wave_shape (
    .timbre  (timbre_in),
    .p       (phase_q[PHASE_W-1 -: PWM_BITS]),
    .vol     (vol_in),
    .level_c (scaled_c)
  );

  // Config inputs only take effect on the wrap edge so a period never changes mid-flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pwm_cnt         <= '0;
      phase_q         <= '0;
      level_q         <= '0;
      pwm_out         <= 1'b0;
      audio_en_out    <= 1'b0;
      sample_tick_out <= 1'b0;
    end else begin
      pwm_cnt         <= pwm_cnt + PWM_BITS'(1);
      pwm_out         <= (pwm_cnt < level_q);
      sample_tick_out <= wrap_c;
      if (wrap_c) begin
        audio_en_out <= sound_on_in;
        if (sound_on_in) begin
          phase_q <= phase_q + phase_inc_c;
          level_q <= scaled_c;
        end else begin
          phase_q <= '0;
          level_q <= '0;
        end
      end
    end
  end

  assign level_out = level_q;

endmodule
